// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned CLK_FREQ             = 50_000_000;
    localparam int unsigned UART_BAUD            = 115_200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_FREQ / UART_BAUD;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter; bit_done marks the final cycle of each bit time.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic bit_done
);

    localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_done = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing with cts-gated stream handshake.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] axis_i_data,
    input  logic       axis_i_vld,
    output logic       axis_i_rdy,
    input  logic       cts,
    output logic       txd,
    output logic       busy
);

    uart_state_t state;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        cts_meta;
    logic        cts_sync;
    logic        bit_done;
    logic        last_stop;
    logic        transfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts;
            cts_sync <= cts_meta;
        end
    end

    // Accepting in the last stop cycle lets a new start bit follow with no idle gap.
    assign last_stop  = (state == STOP) && bit_done && (stop_idx == 1'(STOP_BITS - 1));
    assign axis_i_rdy = !rst && !cts_sync && ((state == IDLE) || last_stop);
    assign transfer   = axis_i_vld && axis_i_rdy;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (transfer),
        .enable  (state != IDLE),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            shift_q  <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state   <= START;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        shift_q <= axis_i_data;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        txd     <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            txd      <= 1'b1;
                            stop_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        if (transfer) begin
                            state   <= START;
                            txd     <= 1'b0;
                            shift_q <= axis_i_data;
                        end else begin
                            state <= IDLE;
                            txd   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else if (bit_done) begin
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
